dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter in front of the data memory. It shares the single memory port between the CPU MEM stage (requester C) and a debug/loader port (requester D). The debug port is used to preload data and to inspect memory while the pipeline runs. The block decides grants and drives the memory command, and it routes returned read data to the owner of each read. It also asserts a stall back to the pipeline whenever the CPU access cannot be serviced in the current cycle.

## Interface
- STARVE_LIMIT, 4: maximum number of consecutive CPU grants while D is requesting, after which D wins one cycle (1..15).
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- c_req  in  1  CPU access request (memRr|memWr of the MEM stage).
- c_we  in  1  CPU write (1) / read (0).
- c_addr  in  32  CPU byte address.
- c_wdata  in  32  CPU write data.
- c_mask  in  4  CPU byte mask (w_mask on write, r_mask on read).
- c_gnt  out  1  CPU command issued to memory this cycle.
- c_stall  out  1  c_req & ~c_gnt; freezes the pipeline.
- c_rvalid  out  1  CPU read data valid.
- c_rdata  out  32  CPU read data.
- d_req, d_we, d_addr[31:0], d_wdata[31:0], d_mask[3:0]  in  debug request, same meaning as the CPU inputs.
- d_lock  in  1  keep D ownership while held (burst).
- d_gnt, d_rvalid, d_rdata[31:0]  out  debug grant, read-valid and read-data, same meaning as the CPU outputs.
- memCe  out  1  memory enable (= c_gnt|d_gnt).
- memWr, memRr  out  1  memory write / read enable.
- memAddr, wtData  out  32  memory address / write data.
- w_mask, r_mask  out  4  byte masks; the mask not in use is 0.
- rdData_i  in  32  memory read data, valid the cycle after a read command.

## Operation
- Grant is combinational from the current requests and the registered state. At most one of c_gnt and d_gnt is high.
- States: IDLE, CPU_PRI, DBG_LOCK.
- IDLE/CPU_PRI use the following priority:
  - The CPU wins when only c_req is high.
  - D wins when only d_req is high.
  - When both are high, the CPU wins unless starve_cnt == STARVE_LIMIT, in which case D wins and starve_cnt clears.
- starve_cnt (4 bit) increments on each cycle where c_gnt & d_req. It clears when d_gnt is high or d_req is low, and saturates at STARVE_LIMIT.
- DBG_LOCK is entered when d_gnt & d_lock. In DBG_LOCK, D owns the port every cycle regardless of c_req. Cycles with d_req low issue no command (memCe 0).
- DBG_LOCK exits to IDLE on the edge where d_lock is low. The cycle in which d_lock is sampled low is arbitrated normally.
- Memory command outputs mux the granted requester's fields. When neither requester is granted, all memory outputs are 0.
- Read return:
  - rd_owner (2 bit: none/C/D) registers the owner of each issued read.
  - Next cycle, the owner's rvalid is 1 and its rdata = rdData_i. The other requester's rvalid is 0 and its rdata holds its last value.
  - Back-to-back reads from alternating owners return in issue order, one per cycle.
- Writes produce no rvalid.

## Timing
- Reset values:
  - c_gnt, d_gnt, c_stall, memCe, memWr, memRr = 0.
  - All address, data and mask outputs = 0.
  - c_rvalid = d_rvalid = 0 and c_rdata = d_rdata = 0.
  - State = IDLE, starve_cnt = 0, rd_owner = none.
- Grant latency is 0 cycles: a request and its grant occur in the same cycle. Read latency is 1 cycle from grant to rvalid.
- A requester holds its request fields stable until it sees a grant. Dropping a request before it is granted is legal and has no side effect.
- Reset asserted mid-read: the pending rvalid is discarded, and no rvalid appears after reset is released.
- If c_req and d_req both rise in the same cycle from IDLE, the CPU is granted.
- If STARVE_LIMIT is reached in the same cycle that d_lock rises, D is granted and the state enters DBG_LOCK.

## Test plan
- CPU only: read at 0x10 with memory holding 0xDEADBEEF at that address.
  - The read is granted in cycle 0, with c_stall 0.
  - c_rvalid = 1 and c_rdata = 0xDEADBEEF in cycle 1.
  - d_rvalid stays 0.
- Contention with STARVE_LIMIT = 4: c_req and d_req held high continuously.
  - c_gnt in cycles 0-3, d_gnt in cycle 4 (c_stall = 1 in that cycle).
  - The pattern repeats with period 5.
- Debug burst: D writes 0x11223344 to address 0x20 with d_lock = 1, then keeps d_lock high for 3 more cycles while c_req = 1.
  - c_stall = 1 for all 4 cycles.
  - The CPU is granted in the first cycle after d_lock falls.
  - A subsequent CPU read of 0x20 returns 0x11223344.
- Alternating reads: C reads 0x0 (value 0xA), D reads 0x4 (value 0xB), and C reads 0x8 (value 0xC) in consecutive cycles.
  - Responses are c_rvalid/0xA, then d_rvalid/0xB, then c_rvalid/0xC on consecutive cycles.
- Byte write: CPU writes 0x000000FF with c_mask = 4'b0001.
  - w_mask = 0001, r_mask = 0000, memWr = 1, memRr = 0.
- Reset mid-operation: assert rst in the cycle a CPU read is granted.
  - All outputs are 0 next cycle, and no c_rvalid appears after rst falls.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Shared data-memory port bundle: CPU requester, debug requester and memory command/return.
interface dmem_arbiter_if;
  logic        c_req;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_mask;
  logic        c_gnt;
  logic        c_stall;
  logic        c_rvalid;
  logic [31:0] c_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_mask;
  logic        d_lock;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        memCe;
  logic        memWr;
  logic        memRr;
  logic [31:0] memAddr;
  logic [31:0] wtData;
  logic [3:0]  w_mask;
  logic [3:0]  r_mask;
  logic [31:0] rdData_i;

  // Arbiter side
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_mask,
    input  d_req, d_we, d_addr, d_wdata, d_mask, d_lock,
    input  rdData_i,
    output c_gnt, c_stall, c_rvalid, c_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output memCe, memWr, memRr, memAddr, wtData, w_mask, r_mask
  );

  // Requesters and memory side
  modport master (
    output c_req, c_we, c_addr, c_wdata, c_mask,
    output d_req, d_we, d_addr, d_wdata, d_mask, d_lock,
    output rdData_i,
    input  c_gnt, c_stall, c_rvalid, c_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  memCe, memWr, memRr, memAddr, wtData, w_mask, r_mask
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and a debug/loader port,
// with starvation relief for debug, locked debug bursts and per-owner read-data return.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCpuPri, StDbgLock} state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
  localparam logic [1:0] OwnNone   = 2'd0;
  localparam logic [1:0] OwnC      = 2'd1;
  localparam logic [1:0] OwnD      = 2'd2;

  state_e      r_state, w_state_next;
  logic [3:0]  r_starve, w_starve_next;
  logic [1:0]  r_rd_owner, w_rd_owner_next;
  logic [31:0] r_c_rdata, r_d_rdata;
  logic        w_c_gnt, w_d_gnt;
  logic        w_c_rvalid, w_d_rvalid;

  // Grants are combinational; reset gates them so every output reads 0 while rst is high.
  always_comb begin
    w_c_gnt      = 1'b0;
    w_d_gnt      = 1'b0;
    w_state_next = r_state;
    if (!rst) begin
      if (r_state == StDbgLock && bus.d_lock) begin
        w_d_gnt = bus.d_req;
      end else if (bus.c_req && bus.d_req) begin
        if (r_starve == StarveMax) w_d_gnt = 1'b1;
        else                       w_c_gnt = 1'b1;
      end else if (bus.c_req) begin
        w_c_gnt = 1'b1;
      end else if (bus.d_req) begin
        w_d_gnt = 1'b1;
      end

      if ((w_d_gnt && bus.d_lock) || (r_state == StDbgLock && bus.d_lock)) begin
        w_state_next = StDbgLock;
      end else if (w_c_gnt) begin
        w_state_next = StCpuPri;
      end else begin
        w_state_next = StIdle;
      end
    end
  end

  always_comb begin
    w_starve_next = r_starve;
    if (w_d_gnt || !bus.d_req) begin
      w_starve_next = 4'd0;
    end else if (w_c_gnt && r_starve < StarveMax) begin
      w_starve_next = r_starve + 4'd1;
    end
  end

  always_comb begin
    w_rd_owner_next = OwnNone;
    if (w_c_gnt && !bus.c_we)      w_rd_owner_next = OwnC;
    else if (w_d_gnt && !bus.d_we) w_rd_owner_next = OwnD;
  end

  always_comb begin
    bus.memCe   = w_c_gnt | w_d_gnt;
    bus.memWr   = 1'b0;
    bus.memRr   = 1'b0;
    bus.memAddr = '0;
    bus.wtData  = '0;
    bus.w_mask  = '0;
    bus.r_mask  = '0;
    if (w_c_gnt) begin
      bus.memWr   = bus.c_we;
      bus.memRr   = ~bus.c_we;
      bus.memAddr = bus.c_addr;
      bus.wtData  = bus.c_wdata;
      bus.w_mask  = bus.c_we ? bus.c_mask : 4'b0000;
      bus.r_mask  = bus.c_we ? 4'b0000 : bus.c_mask;
    end else if (w_d_gnt) begin
      bus.memWr   = bus.d_we;
      bus.memRr   = ~bus.d_we;
      bus.memAddr = bus.d_addr;
      bus.wtData  = bus.d_wdata;
      bus.w_mask  = bus.d_we ? bus.d_mask : 4'b0000;
      bus.r_mask  = bus.d_we ? 4'b0000 : bus.d_mask;
    end
  end

  // The non-owning side keeps presenting the last data it received.
  assign w_c_rvalid   = (r_rd_owner == OwnC);
  assign w_d_rvalid   = (r_rd_owner == OwnD);
  assign bus.c_gnt    = w_c_gnt;
  assign bus.d_gnt    = w_d_gnt;
  assign bus.c_stall  = bus.c_req & ~w_c_gnt & ~rst;
  assign bus.c_rvalid = w_c_rvalid;
  assign bus.d_rvalid = w_d_rvalid;
  assign bus.c_rdata  = w_c_rvalid ? bus.rdData_i : r_c_rdata;
  assign bus.d_rdata  = w_d_rvalid ? bus.rdData_i : r_d_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_starve   <= 4'd0;
      r_rd_owner <= OwnNone;
      r_c_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_starve   <= w_starve_next;
      r_rd_owner <= w_rd_owner_next;
      if (w_c_rvalid) r_c_rdata <= bus.rdData_i;
      if (w_d_rvalid) r_d_rdata <= bus.rdData_i;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: inputs driven on the falling edge, outputs sampled 1 ns later,
// with a small byte-masked memory model answering reads one cycle after the command.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem [0:63];

  always @(posedge clk) begin
    if (rst) begin
      bus.rdData_i <= '0;
    end else begin
      if (bus.memWr) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.w_mask[b]) mem[bus.memAddr[7:2]][8*b +: 8] <= bus.wtData[8*b +: 8];
        end
      end
      if (bus.memRr) bus.rdData_i <= mem[bus.memAddr[7:2]];
    end
  end

  task automatic idle_inputs();
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_mask = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_mask = '0;
    bus.d_lock = 1'b0;
  endtask

  // Preload through the debug port (its intended use), no checks here.
  task automatic d_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = addr; bus.d_wdata = data;
    bus.d_mask = 4'hF; bus.d_lock = 1'b0;
    @(negedge clk);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bus.c_gnt, bus.d_gnt, bus.c_stall, bus.c_rvalid, bus.d_rvalid,
           bus.memCe, bus.memWr, bus.memRr} !== 8'h00) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: got %b want 00000000", k,
                 {bus.c_gnt, bus.d_gnt, bus.c_stall, bus.c_rvalid, bus.d_rvalid,
                  bus.memCe, bus.memWr, bus.memRr});
      end
      checks++;
      if ({bus.memAddr, bus.wtData, bus.w_mask, bus.r_mask, bus.c_rdata, bus.d_rdata} !== '0) begin
        errors++;
        $display("FAIL reset_data[%0d]: addr %h wdata %h wm %b rm %b crd %h drd %h want all 0",
                 k, bus.memAddr, bus.wtData, bus.w_mask, bus.r_mask, bus.c_rdata, bus.d_rdata);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
    end
  endtask

  task automatic test_cpu_read();
    d_write(32'h10, 32'hDEADBEEF);
    @(negedge clk);
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h10; bus.c_mask = 4'hF;
    #1;
    checks++;
    if ({bus.c_gnt, bus.d_gnt, bus.c_stall, bus.memRr, bus.memWr} !== 5'b10010) begin
      errors++;
      $display("FAIL cpu_read_gnt: gnt/dgnt/stall/rr/wr %b want 10010",
               {bus.c_gnt, bus.d_gnt, bus.c_stall, bus.memRr, bus.memWr});
    end
    checks++;
    if ({bus.memAddr, bus.r_mask, bus.w_mask} !== {32'h10, 4'hF, 4'h0}) begin
      errors++;
      $display("FAIL cpu_read_cmd: addr %h rm %b wm %b want 00000010 1111 0000",
               bus.memAddr, bus.r_mask, bus.w_mask);
    end
    @(negedge clk);
    bus.c_req = 1'b0;
    #1;
    checks++;
    if ({bus.c_rvalid, bus.d_rvalid, bus.c_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL cpu_read_ret: crv %b drv %b crd %h want 1 0 deadbeef",
               bus.c_rvalid, bus.d_rvalid, bus.c_rdata);
    end
  endtask

  task automatic test_contention();
    logic [2:0] exp;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h0; bus.c_mask = 4'hF;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4; bus.d_mask = 4'hF;
      end
      #1;
      exp = (cyc % 5 == 4) ? 3'b011 : 3'b100;
      checks++;
      if ({bus.c_gnt, bus.d_gnt, bus.c_stall} !== exp) begin
        errors++;
        $display("FAIL contention[%0d]: cgnt/dgnt/stall %b want %b", cyc,
                 {bus.c_gnt, bus.d_gnt, bus.c_stall}, exp);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_debug_burst();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h11223344;
    bus.d_mask = 4'hF; bus.d_lock = 1'b1;
    #1;
    checks++;
    if ({bus.c_gnt, bus.d_gnt, bus.memWr, bus.wtData} !== {3'b011, 32'h11223344}) begin
      errors++;
      $display("FAIL burst_write: cgnt %b dgnt %b wr %b wdata %h want 0 1 1 11223344",
               bus.c_gnt, bus.d_gnt, bus.memWr, bus.wtData);
    end
    for (int cyc = 1; cyc < 4; cyc++) begin
      @(negedge clk);
      bus.d_req = 1'b0; bus.d_we = 1'b0;
      bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h20; bus.c_mask = 4'hF;
      #1;
      checks++;
      if ({bus.c_gnt, bus.d_gnt, bus.c_stall, bus.memCe} !== 4'b0010) begin
        errors++;
        $display("FAIL burst_lock[%0d]: cgnt/dgnt/stall/ce %b want 0010", cyc,
                 {bus.c_gnt, bus.d_gnt, bus.c_stall, bus.memCe});
      end
    end
    @(negedge clk);
    bus.d_lock = 1'b0;
    #1;
    checks++;
    if ({bus.c_gnt, bus.c_stall, bus.memRr} !== 3'b101) begin
      errors++;
      $display("FAIL burst_release: cgnt/stall/rr %b want 101",
               {bus.c_gnt, bus.c_stall, bus.memRr});
    end
    @(negedge clk);
    bus.c_req = 1'b0;
    #1;
    checks++;
    if ({bus.c_rvalid, bus.c_rdata} !== {1'b1, 32'h11223344}) begin
      errors++;
      $display("FAIL burst_readback: crv %b crd %h want 1 11223344", bus.c_rvalid, bus.c_rdata);
    end
  endtask

  task automatic test_back_to_back();
    d_write(32'h0, 32'hA);
    d_write(32'h4, 32'hB);
    d_write(32'h8, 32'hC);
    @(negedge clk);
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h0; bus.c_mask = 4'hF;
    #1;
    checks++;
    if (bus.c_gnt !== 1'b1) begin
      errors++;
      $display("FAIL alt_c0_gnt: cgnt %b want 1", bus.c_gnt);
    end
    @(negedge clk);
    bus.c_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4; bus.d_mask = 4'hF;
    #1;
    checks++;
    if ({bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.c_rdata} !== {3'b110, 32'hA}) begin
      errors++;
      $display("FAIL alt_ret_a: dgnt %b crv %b drv %b crd %h want 1 1 0 0000000a",
               bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.c_rdata);
    end
    @(negedge clk);
    bus.d_req = 1'b0;
    bus.c_req = 1'b1; bus.c_addr = 32'h8;
    #1;
    checks++;
    if ({bus.c_gnt, bus.c_rvalid, bus.d_rvalid, bus.d_rdata, bus.c_rdata}
        !== {3'b101, 32'hB, 32'hA}) begin
      errors++;
      $display("FAIL alt_ret_b: cgnt %b crv %b drv %b drd %h crd %h want 1 0 1 0000000b 0000000a",
               bus.c_gnt, bus.c_rvalid, bus.d_rvalid, bus.d_rdata, bus.c_rdata);
    end
    @(negedge clk);
    bus.c_req = 1'b0;
    #1;
    checks++;
    if ({bus.c_rvalid, bus.d_rvalid, bus.c_rdata, bus.d_rdata} !== {2'b10, 32'hC, 32'hB}) begin
      errors++;
      $display("FAIL alt_ret_c: crv %b drv %b crd %h drd %h want 1 0 0000000c 0000000b",
               bus.c_rvalid, bus.d_rvalid, bus.c_rdata, bus.d_rdata);
    end
  endtask

  task automatic test_byte_write();
    d_write(32'h30, 32'hAABBCCDD);
    @(negedge clk);
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h30; bus.c_wdata = 32'hFF;
    bus.c_mask = 4'b0001;
    #1;
    checks++;
    if ({bus.c_gnt, bus.memWr, bus.memRr, bus.w_mask, bus.r_mask, bus.wtData}
        !== {3'b110, 4'b0001, 4'b0000, 32'hFF}) begin
      errors++;
      $display("FAIL byte_write: gnt %b wr %b rr %b wm %b rm %b wdata %h want 1 1 0 0001 0000 ff",
               bus.c_gnt, bus.memWr, bus.memRr, bus.w_mask, bus.r_mask, bus.wtData);
    end
    @(negedge clk);
    bus.c_we = 1'b0; bus.c_mask = 4'hF;
    @(negedge clk);
    bus.c_req = 1'b0;
    #1;
    checks++;
    if ({bus.c_rvalid, bus.c_rdata} !== {1'b1, 32'hAABBCCFF}) begin
      errors++;
      $display("FAIL byte_readback: crv %b crd %h want 1 aabbccff", bus.c_rvalid, bus.c_rdata);
    end
  endtask

  task automatic test_lock_at_limit();
    logic [2:0] exp;
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h0; bus.c_mask = 4'hF;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4; bus.d_mask = 4'hF;
      end
      if (cyc == 4) bus.d_lock = 1'b1;
      if (cyc == 6) begin
        bus.d_lock = 1'b0; bus.d_req = 1'b0;
      end
      #1;
      exp = (cyc == 4 || cyc == 5) ? 3'b011 : 3'b100;
      checks++;
      if ({bus.c_gnt, bus.d_gnt, bus.c_stall} !== exp) begin
        errors++;
        $display("FAIL lock_at_limit[%0d]: cgnt/dgnt/stall %b want %b", cyc,
                 {bus.c_gnt, bus.d_gnt, bus.c_stall}, exp);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h10; bus.c_mask = 4'hF;
    #1;
    checks++;
    if (bus.c_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_gnt: cgnt %b want 1", bus.c_gnt);
    end
    rst = 1'b1;
    @(negedge clk);
    bus.c_req = 1'b0;
    #1;
    checks++;
    if ({bus.c_gnt, bus.d_gnt, bus.c_stall, bus.c_rvalid, bus.d_rvalid, bus.memCe, bus.memWr,
         bus.memRr, bus.memAddr, bus.wtData, bus.w_mask, bus.r_mask, bus.c_rdata, bus.d_rdata}
        !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: ctrl %b addr %h crd %h drd %h want all 0",
               {bus.c_gnt, bus.d_gnt, bus.c_stall, bus.c_rvalid, bus.d_rvalid, bus.memCe,
                bus.memWr, bus.memRr}, bus.memAddr, bus.c_rdata, bus.d_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk); #1;
      checks++;
      if ({bus.c_rvalid, bus.d_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL rst_mid_no_rvalid[%0d]: crv %b drv %b want 0 0", cyc,
                 bus.c_rvalid, bus.d_rvalid);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cpu_read();
    test_contention();
    test_debug_burst();
    test_back_to_back();
    test_byte_write();
    test_lock_at_limit();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
